// File: rtl/conv_operand_sram.sv
// Operand store for a convolver: host loads a kernel and two window buffers,
// then the block pulses start and serves registered reads until conv_done.
module conv_operand_sram #(
  parameter int KERNEL_SIZE     = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_ADDR_WIDTH = 4,
  parameter int SRAM_DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_load_valid,
  input  logic [DATA_WIDTH-1:0]      i_load_data,
  output logic                       o_load_ready,
  output logic                       o_start,
  output logic                       o_operands_valid,
  input  logic                       i_conv_done,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_kernel_addr,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_window1_addr,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_window2_addr,
  output logic [DATA_WIDTH-1:0]      o_kernel_data,
  output logic [DATA_WIDTH-1:0]      o_window1_data,
  output logic [DATA_WIDTH-1:0]      o_window2_data,
  output logic                       o_addr_err
);

  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int MAXN = (KK > SRAM_DEPTH) ? KK : SRAM_DEPTH;
  localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

  localparam logic [CW-1:0] KLAST = CW'(KK - 1);
  localparam logic [CW-1:0] WLAST = CW'(SRAM_DEPTH - 1);

  localparam logic [2:0] LOAD_KERNEL = 3'd0;
  localparam logic [2:0] LOAD_WIN1   = 3'd1;
  localparam logic [2:0] LOAD_WIN2   = 3'd2;
  localparam logic [2:0] START       = 3'd3;
  localparam logic [2:0] SERVE       = 3'd4;

  logic [2:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_kmem [KK];
  logic [DATA_WIDTH-1:0] r_w1   [SRAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_w2   [SRAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_kdata;
  logic [DATA_WIDTH-1:0] r_w1data;
  logic [DATA_WIDTH-1:0] r_w2data;
  logic                  r_err;

  logic w_in_load;
  logic w_xfer;
  logic w_k_ok;
  logic w_w1_ok;
  logic w_w2_ok;

  assign w_in_load = (r_state == LOAD_KERNEL) ||
                     (r_state == LOAD_WIN1) ||
                     (r_state == LOAD_WIN2);

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign o_load_ready     = w_in_load & i_rst_n;
  assign w_xfer           = i_load_valid & o_load_ready;
  assign o_start          = (r_state == START);
  assign o_operands_valid = (r_state == SERVE);

  assign w_k_ok  = 32'(i_kernel_addr) < KK;
  assign w_w1_ok = 32'(i_window1_addr) < SRAM_DEPTH;
  assign w_w2_ok = 32'(i_window2_addr) < SRAM_DEPTH;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LOAD_KERNEL;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        LOAD_KERNEL: if (w_xfer) begin
          if (r_cnt == KLAST) begin
            r_state <= LOAD_WIN1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LOAD_WIN1: if (w_xfer) begin
          if (r_cnt == WLAST) begin
            r_state <= LOAD_WIN2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LOAD_WIN2: if (w_xfer) begin
          if (r_cnt == WLAST) begin
            r_state <= START;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        START: r_state <= SERVE;
        SERVE: if (i_conv_done) r_state <= LOAD_KERNEL;
        default: begin
          r_state <= LOAD_KERNEL;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Storage survives reset on purpose.
  always_ff @(posedge i_clk) begin
    if (w_xfer) begin
      case (r_state)
        LOAD_KERNEL: r_kmem[r_cnt] <= i_load_data;
        LOAD_WIN1:   r_w1[r_cnt]   <= i_load_data;
        LOAD_WIN2:   r_w2[r_cnt]   <= i_load_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kdata  <= '0;
      r_w1data <= '0;
      r_w2data <= '0;
      r_err    <= 1'b0;
    end else begin
      r_kdata  <= w_k_ok  ? r_kmem[i_kernel_addr] : '0;
      r_w1data <= w_w1_ok ? r_w1[i_window1_addr]  : '0;
      r_w2data <= w_w2_ok ? r_w2[i_window2_addr]  : '0;
      if (!w_k_ok || !w_w1_ok || !w_w2_ok) r_err <= 1'b1;
    end
  end

  assign o_kernel_data  = r_kdata;
  assign o_window1_data = r_w1data;
  assign o_window2_data = r_w2data;
  assign o_addr_err     = r_err;

endmodule
